// File: rtl/acc_pkg.sv
// Shared constants for the multi-channel accumulator: operand-select encodings
// and default widths.
package acc_pkg;

  localparam logic [1:0] SEL_D1   = 2'b00;
  localparam logic [1:0] SEL_D2   = 2'b01;
  localparam logic [1:0] SEL_SUM  = 2'b10;
  localparam logic [1:0] SEL_HOLD = 2'b11;

  localparam int ACC_NB_IDATA = 3;
  localparam int ACC_NB_ODATA = 6;
  localparam int ACC_NB_SEL   = 2;
  localparam int ACC_N_CH     = 4;

endpackage

// File: rtl/acc_opsel.sv
// Operand select/adder and the stage-1 register of the multi-channel accumulator.
module acc_opsel
  import acc_pkg::*;
#(
  parameter int NB_IDATA = ACC_NB_IDATA,
  parameter int NB_SEL   = ACC_NB_SEL,
  parameter int NB_CH    = 2
) (
  input  logic                clk,
  input  logic                i_rst_n,
  input  logic                i_valid,
  input  logic [NB_CH-1:0]    i_ch,
  input  logic [NB_SEL-1:0]   i_sel,
  input  logic                i_clear,
  input  logic [NB_IDATA-1:0] i_data1,
  input  logic [NB_IDATA-1:0] i_data2,
  output logic                vld_p1,
  output logic [NB_CH-1:0]    ch_p1,
  output logic                clr_p1,
  output logic                hold_p1,
  output logic [NB_IDATA:0]   mux_p1
);

  logic [NB_IDATA:0] op_p0;
  logic              hold_p0;

  always_comb begin
    op_p0   = '0;
    hold_p0 = (i_sel == NB_SEL'(SEL_HOLD));
    case (i_sel)
      NB_SEL'(SEL_D1):  op_p0 = {1'b0, i_data1};
      NB_SEL'(SEL_D2):  op_p0 = {1'b0, i_data2};
      NB_SEL'(SEL_SUM): op_p0 = {1'b0, i_data1} + {1'b0, i_data2};
      default:          op_p0 = '0;
    endcase
  end

  // stage 1: operand and beat attributes; payload only moves on valid beats
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      vld_p1  <= 1'b0;
      ch_p1   <= '0;
      clr_p1  <= 1'b0;
      hold_p1 <= 1'b0;
      mux_p1  <= '0;
    end else begin
      vld_p1 <= i_valid;
      if (i_valid) begin
        ch_p1   <= i_ch;
        clr_p1  <= i_clear;
        hold_p1 <= hold_p0;
        mux_p1  <= op_p0;
      end
    end
  end

endmodule

// File: rtl/acc_mch.sv
// Multi-channel pipelined accumulator with per-channel clear/load and sticky overflow.
// Define ACC_MCH_SATURATE_EN to saturate on carry-out instead of wrapping.
module acc_mch
  import acc_pkg::*;
#(
  parameter int NB_IDATA = ACC_NB_IDATA,
  parameter int NB_ODATA = ACC_NB_ODATA,
  parameter int NB_SEL   = ACC_NB_SEL,
  parameter int N_CH     = ACC_N_CH,
  parameter int NB_CH    = $clog2(N_CH)
) (
  input  logic                clk,
  input  logic                i_rst_n,
  input  logic                i_valid,
  input  logic [NB_CH-1:0]    i_ch,
  input  logic [NB_SEL-1:0]   i_sel,
  input  logic                i_clear,
  input  logic [NB_IDATA-1:0] i_data1,
  input  logic [NB_IDATA-1:0] i_data2,
  output logic                o_valid,
  output logic [NB_CH-1:0]    o_ch,
  output logic [NB_IDATA:0]   o_mux,
  output logic [NB_ODATA-1:0] o_data,
  output logic                o_overflow
);

  function automatic logic [NB_ODATA-1:0] fold(input logic [NB_ODATA:0] s);
`ifdef ACC_MCH_SATURATE_EN
    fold = s[NB_ODATA] ? '1 : s[NB_ODATA-1:0];
`else
    fold = s[NB_ODATA-1:0];
`endif
  endfunction

  logic ch_ok;

  generate
    if (N_CH == (1 << NB_CH)) begin : g_full
      assign ch_ok = 1'b1;
    end else begin : g_partial
      assign ch_ok = (int'(i_ch) < N_CH);
    end
  endgenerate

  logic             vld_p1, clr_p1, hold_p1;
  logic [NB_CH-1:0] ch_p1;

  acc_opsel #(
    .NB_IDATA (NB_IDATA),
    .NB_SEL   (NB_SEL),
    .NB_CH    (NB_CH)
  ) u_opsel (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .i_valid (i_valid & ch_ok),
    .i_ch    (i_ch),
    .i_sel   (i_sel),
    .i_clear (i_clear),
    .i_data1 (i_data1),
    .i_data2 (i_data2),
    .vld_p1  (vld_p1),
    .ch_p1   (ch_p1),
    .clr_p1  (clr_p1),
    .hold_p1 (hold_p1),
    .mux_p1  (o_mux)
  );

  logic [NB_ODATA-1:0] acc_mem [N_CH];
  logic [N_CH-1:0]     flag_mem;
  logic [NB_ODATA:0]   sum_p2;
  logic [NB_ODATA-1:0] acc_nxt_p2;
  logic                flag_nxt_p2;

  // Hold beats carry a zero operand, so only clear needs the hold override.
  always_comb begin
    sum_p2      = {1'b0, acc_mem[ch_p1]} + (NB_ODATA+1)'(o_mux);
    acc_nxt_p2  = fold(sum_p2);
    flag_nxt_p2 = flag_mem[ch_p1] | sum_p2[NB_ODATA];
    if (clr_p1 && !hold_p1) begin
      acc_nxt_p2  = NB_ODATA'(o_mux);
      flag_nxt_p2 = 1'b0;
    end
  end

  // stage 2: read-modify-write of the channel array in one cycle (no hazard)
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < N_CH; i++) acc_mem[i] <= '0;
      flag_mem   <= '0;
      o_valid    <= 1'b0;
      o_ch       <= '0;
      o_data     <= '0;
      o_overflow <= 1'b0;
    end else begin
      o_valid <= vld_p1;
      if (vld_p1) begin
        acc_mem[ch_p1]  <= acc_nxt_p2;
        flag_mem[ch_p1] <= flag_nxt_p2;
        o_ch            <= ch_p1;
        o_data          <= acc_nxt_p2;
        o_overflow      <= flag_nxt_p2;
      end
    end
  end

endmodule

// File: tb/tb_acc_mch.sv
// Self-checking bench for acc_mch: per-channel reference model with a 2-beat
// latency queue, checked every cycle, plus hand-computed literal expectations.
module tb_acc_mch;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid;
  logic [1:0] ch;
  logic [1:0] sel;
  logic       clr;
  logic [2:0] d1, d2;
  logic       o_valid;
  logic [1:0] o_ch;
  logic [3:0] o_mux;
  logic [5:0] o_data;
  logic       o_overflow;

  always #5 clk = ~clk;

  acc_mch dut (
    .clk        (clk),
    .i_rst_n    (rst_n),
    .i_valid    (valid),
    .i_ch       (ch),
    .i_sel      (sel),
    .i_clear    (clr),
    .i_data1    (d1),
    .i_data2    (d2),
    .o_valid    (o_valid),
    .o_ch       (o_ch),
    .o_mux      (o_mux),
    .o_data     (o_data),
    .o_overflow (o_overflow)
  );

  typedef struct {
    bit vld;
    int ch;
    int data;
    bit ovf;
    bit lit_en;
    int lit_data;
    bit lit_ovf;
    int lit_mux;
  } rec_t;

  int   checks = 0;
  int   errors = 0;
  rec_t e1, e2;
  int   m_acc [4];
  bit   m_flg [4];
  int   m_mux, last_ch, last_data;
  bit   last_ovf;
  bit   run = 0;
  bit   lit_en;
  int   lit_data, lit_mux;
  bit   lit_ovf;

`ifdef ACC_MCH_SATURATE_EN
  localparam int WRAP5 = 63;
`else
  localparam int WRAP5 = 6;
`endif

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: each accepted beat is resolved with plain arithmetic
  // when it is sampled, then shows up on the outputs two edges later.
  always @(posedge clk) begin
    rec_t n;
    int op, s;
    n = '{default: 0};
    n.lit_mux = -1;
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        m_acc[i] = 0;
        m_flg[i] = 0;
      end
      e1 = n; e2 = n; m_mux = 0;
      last_ch = 0; last_data = 0; last_ovf = 0;
      run = 1;
    end else begin
      e2 = e1;
      if (valid === 1'b1) begin
        case (sel)
          2'd0:    op = int'(d1);
          2'd1:    op = int'(d2);
          2'd2:    op = int'(d1) + int'(d2);
          default: op = 0;
        endcase
        m_mux = op;
        if (clr && sel != 2'd3) begin
          m_acc[ch] = op;
          m_flg[ch] = 0;
        end else begin
          s = m_acc[ch] + op;
          if (s > 63) begin
            m_flg[ch] = 1;
`ifdef ACC_MCH_SATURATE_EN
            m_acc[ch] = 63;
`else
            m_acc[ch] = s - 64;
`endif
          end else begin
            m_acc[ch] = s;
          end
        end
        n.vld = 1; n.ch = int'(ch); n.data = m_acc[ch]; n.ovf = m_flg[ch];
        n.lit_en = lit_en; n.lit_data = lit_data; n.lit_ovf = lit_ovf; n.lit_mux = lit_mux;
      end
      e1 = n;
    end
  end

  always @(negedge clk) begin
    if (run) begin
      chk("o_valid", int'(o_valid), int'(e2.vld));
      chk("o_mux", int'(o_mux), m_mux);
      if (e2.vld) begin
        last_ch = e2.ch; last_data = e2.data; last_ovf = e2.ovf;
      end
      chk("o_ch", int'(o_ch), last_ch);
      chk("o_data", int'(o_data), last_data);
      chk("o_overflow", int'(o_overflow), int'(last_ovf));
      if (e2.vld && e2.lit_en) begin
        chk("lit_data", int'(o_data), e2.lit_data);
        chk("lit_ovf", int'(o_overflow), int'(e2.lit_ovf));
        chk("model_pin", e2.data, e2.lit_data);
        if (e2.lit_mux >= 0) chk("lit_mux", int'(o_mux), e2.lit_mux);
      end
    end
  end

  task automatic beat(input int c, input int s, input bit cl, input int a, input int b,
                      input bit le, input int ld, input bit lo, input int lm);
    valid = 1'b1; ch = 2'(c); sel = 2'(s); clr = cl; d1 = 3'(a); d2 = 3'(b);
    lit_en = le; lit_data = ld; lit_ovf = lo; lit_mux = lm;
    @(posedge clk); #1;
    valid = 1'b0; lit_en = 1'b0;
  endtask

  task automatic idle(input int n);
    valid = 1'b0; lit_en = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    rst_n = 1'b0; valid = 1'b0; ch = '0; sel = '0; clr = 1'b0; d1 = '0; d2 = '0;
    lit_en = 1'b0; lit_data = 0; lit_ovf = 1'b0; lit_mux = -1;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("rst_o_valid", int'(o_valid), 0);
    chk("rst_o_data", int'(o_data), 0);
    chk("rst_o_mux", int'(o_mux), 0);
    chk("rst_o_ovf", int'(o_overflow), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // test 1: sum mode, first result
    beat(0, 2, 0, 3, 2, 1, 5, 0, 5);
    idle(3);

    // test 3: interleaved channels, then hold probes of untouched channels
    beat(0, 0, 1, 4, 0, 1, 4, 0, -1);
    beat(2, 1, 0, 0, 6, 1, 6, 0, -1);
    beat(0, 0, 0, 1, 0, 1, 5, 0, -1);
    beat(3, 3, 0, 5, 5, 1, 0, 0, -1);
    beat(1, 3, 1, 5, 5, 1, 0, 0, -1);

    // test 2: back-to-back accumulation into ch1 until carry-out
    beat(1, 2, 0, 7, 7, 1, 14, 0, -1);
    beat(1, 2, 0, 7, 7, 1, 28, 0, -1);
    beat(1, 2, 0, 7, 7, 1, 42, 0, -1);
    beat(1, 2, 0, 7, 7, 1, 56, 0, -1);
    beat(1, 2, 0, 7, 7, 1, WRAP5, 1, -1);

    // test 4: clear drops the sticky flag; hold with clear leaves it alone
    beat(1, 1, 1, 0, 3, 1, 3, 0, -1);
    beat(1, 3, 1, 7, 7, 1, 3, 0, -1);
    idle(2);

    // test 5: reset pulse with beats in flight
    beat(0, 0, 0, 1, 0, 0, 0, 0, -1);
    beat(2, 0, 0, 1, 0, 0, 0, 0, -1);
    rst_n = 1'b0;
    beat(1, 0, 0, 1, 0, 0, 0, 0, -1);
    rst_n = 1'b1;
    beat(2, 0, 0, 3, 0, 1, 3, 0, -1);
    beat(0, 0, 0, 1, 0, 1, 1, 0, -1);
    idle(2);

    // test 6: idle with noisy inputs leaves all channels untouched
    for (int i = 0; i < 10; i++) begin
      ch = 2'($urandom_range(0, 3)); sel = 2'($urandom_range(0, 3));
      clr = 1'($urandom_range(0, 1)); d1 = 3'($urandom_range(0, 7)); d2 = 3'($urandom_range(0, 7));
      @(posedge clk); #1;
    end
    beat(0, 0, 0, 0, 0, 1, 1, 0, -1);
    beat(2, 0, 0, 0, 0, 1, 3, 0, -1);
    beat(1, 0, 0, 0, 0, 1, 0, 0, -1);
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
